// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller for a single-cycle RISC-V datapath.
// Owns the architectural PC, runs a post-reset boot hold, retires one
// instruction per non-stalled RUN cycle, and parks in HALT or TRAP until reset.
module pc_sequencer #(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VEC   = {WIDTH{1'b0}},
    parameter int unsigned      BOOT_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             branch_i,
    input  logic             branch_taken_i,
    input  logic             jal_i,
    input  logic             jalr_i,
    input  logic [WIDTH-1:0] imm_i,
    input  logic [WIDTH-1:0] rs1_i,
    input  logic             stall_i,
    input  logic             halt_req_i,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus4_o,
    output logic             run_o,
    output logic             halted_o,
    output logic             trap_o,
    output logic [WIDTH-1:0] trap_pc_o,
    output logic [31:0]      retired_o
);

    // Boot counter must hold BOOT_CYCLES itself; keep at least one bit so
    // BOOT_CYCLES = 0 still yields a legal vector.
    localparam int unsigned      CNT_W     = (BOOT_CYCLES > 0) ? $clog2(BOOT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] BOOT_LOAD = CNT_W'(BOOT_CYCLES);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2,
        S_TRAP = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] boot_cnt;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] trap_pc;
    logic [31:0]      retired;

    logic signed [WIDTH-1:0] imm_s;
    logic [WIDTH-1:0]        seq_pc;
    logic [WIDTH-1:0]        rel_target;
    logic [WIDTH-1:0]        jalr_target;
    logic [WIDTH-1:0]        next_pc;
    logic                    take_xfer;
    logic                    misaligned;

    // Base plus sign-extended offset, wrapping modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] offset_add(
        input logic [WIDTH-1:0]        base,
        input logic signed [WIDTH-1:0] offset
    );
        offset_add = base + $unsigned(offset);
    endfunction

    // JALR discards bit 0 of the computed address; bit 1 is left for the
    // alignment check.
    function automatic logic [WIDTH-1:0] clear_lsb(input logic [WIDTH-1:0] addr);
        clear_lsb = {addr[WIDTH-1:1], 1'b0};
    endfunction

    assign imm_s       = $signed(imm_i);
    assign seq_pc      = pc + WIDTH'(4);
    assign rel_target  = offset_add(pc, imm_s);
    assign jalr_target = clear_lsb(offset_add(rs1_i, imm_s));

    // Next-PC select: JALR over JAL over taken branch over sequential; the
    // fixed priority also settles illegal combinations of decode strobes.
    always_comb begin
        next_pc   = seq_pc;
        take_xfer = 1'b0;
        if (jalr_i) begin
            next_pc   = jalr_target;
            take_xfer = 1'b1;
        end else if (jal_i) begin
            next_pc   = rel_target;
            take_xfer = 1'b1;
        end else if (branch_i && branch_taken_i) begin
            next_pc   = rel_target;
            take_xfer = 1'b1;
        end
        // Only a control transfer can land off a word boundary.
        misaligned = take_xfer & next_pc[1];
    end

    // Sequencer FSM: boot hold, execute, and the two terminal states.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_BOOT;
            boot_cnt <= BOOT_LOAD;
            pc       <= RESET_VEC;
            trap_pc  <= {WIDTH{1'b0}};
            retired  <= 32'd0;
        end else begin
            case (state)
                S_BOOT: begin
                    if (boot_cnt == {CNT_W{1'b0}}) begin
                        state <= S_RUN;
                    end else begin
                        boot_cnt <= boot_cnt - CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (!stall_i) begin
                        if (halt_req_i) begin
                            // ECALL/EBREAK retires but the PC stays on it.
                            state   <= S_HALT;
                            retired <= retired + 32'd1;
                        end else if (misaligned) begin
                            // Faulting instruction does not retire.
                            state   <= S_TRAP;
                            trap_pc <= pc;
                        end else begin
                            pc      <= next_pc;
                            retired <= retired + 32'd1;
                        end
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                S_TRAP: begin
                    state <= S_TRAP;
                end
                default: begin
                    state <= S_BOOT;
                end
            endcase
        end
    end

    assign pc_out     = pc;
    assign pc_plus4_o = seq_pc;
    assign run_o      = (state == S_RUN);
    assign halted_o   = (state == S_HALT);
    assign trap_o     = (state == S_TRAP);
    assign trap_pc_o  = trap_pc;
    assign retired_o  = retired;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer (WIDTH 32, RESET_VEC 0,
// BOOT_CYCLES 4). Each driven cycle pushes the expected post-edge state.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam int          BC = 4;

    logic        clk;
    logic        reset;
    logic        branch_i, branch_taken_i, jal_i, jalr_i, stall_i, halt_req_i;
    logic [31:0] imm_i, rs1_i;
    logic [31:0] pc_out, pc_plus4_o, trap_pc_o, retired_o;
    logic        run_o, halted_o, trap_o;

    pc_sequencer #(.WIDTH(32), .RESET_VEC(RV), .BOOT_CYCLES(BC)) dut (
        .clk(clk), .reset(reset),
        .branch_i(branch_i), .branch_taken_i(branch_taken_i),
        .jal_i(jal_i), .jalr_i(jalr_i),
        .imm_i(imm_i), .rs1_i(rs1_i),
        .stall_i(stall_i), .halt_req_i(halt_req_i),
        .pc_out(pc_out), .pc_plus4_o(pc_plus4_o),
        .run_o(run_o), .halted_o(halted_o), .trap_o(trap_o),
        .trap_pc_o(trap_pc_o), .retired_o(retired_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ret;
        logic [31:0] tpc;
        int          st;   // 0 boot, 1 run, 2 halt, 3 trap
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference state
    int          m_st;
    int          m_cnt;
    logic [31:0] m_pc, m_ret, m_tpc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance the reference by one rising edge using the current inputs.
    task automatic model_step();
        logic [31:0] tgt;
        logic        take;
        if (!reset) begin
            m_st = 0; m_cnt = BC; m_pc = RV; m_ret = 0; m_tpc = 0;
        end else begin
            case (m_st)
                0: if (m_cnt == 0) m_st = 1; else m_cnt = m_cnt - 1;
                1: if (!stall_i) begin
                    if (halt_req_i) begin
                        m_st = 2; m_ret = m_ret + 1;
                    end else begin
                        take = 1'b1;
                        if (jalr_i)                        tgt = (rs1_i + imm_i) & 32'hFFFF_FFFE;
                        else if (jal_i)                    tgt = m_pc + imm_i;
                        else if (branch_i && branch_taken_i) tgt = m_pc + imm_i;
                        else begin take = 1'b0; tgt = m_pc + 32'd4; end
                        if (take && tgt[1]) begin
                            m_st = 3; m_tpc = m_pc;
                        end else begin
                            m_pc = tgt; m_ret = m_ret + 1;
                        end
                    end
                end
                default: ;
            endcase
        end
    endtask

    // Drive one cycle: push expectation, clock, pop and compare every output.
    task automatic step(input string tag);
        exp_t e;
        exp_t g;
        model_step();
        e.pc = m_pc; e.ret = m_ret; e.tpc = m_tpc; e.st = m_st;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            g = sb.pop_front();
            check($sformatf("%s.pc", tag),      pc_out,           g.pc);
            check($sformatf("%s.plus4", tag),   pc_plus4_o,       g.pc + 32'd4);
            check($sformatf("%s.retired", tag), retired_o,        g.ret);
            check($sformatf("%s.trap_pc", tag), trap_pc_o,        g.tpc);
            check($sformatf("%s.run", tag),     32'(run_o),       (g.st == 1) ? 32'd1 : 32'd0);
            check($sformatf("%s.halted", tag),  32'(halted_o),    (g.st == 2) ? 32'd1 : 32'd0);
            check($sformatf("%s.trap", tag),    32'(trap_o),      (g.st == 3) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic drive(input logic br, input logic tk, input logic jl, input logic jr,
                         input logic [31:0] imm, input logic [31:0] rs1,
                         input logic st, input logic hr);
        branch_i = br; branch_taken_i = tk; jal_i = jl; jalr_i = jr;
        imm_i = imm; rs1_i = rs1; stall_i = st; halt_req_i = hr;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 32'd0, 32'd0, 0, 0);
    endtask

    task automatic jump_to(input logic [31:0] addr);
        drive(0, 0, 0, 1, 32'd0, addr, 0, 0);
        step("jump_to");
        idle();
    endtask

    task automatic check_reset_values(input string tag);
        check($sformatf("%s.pc", tag),      pc_out,        RV);
        check($sformatf("%s.run", tag),     32'(run_o),    32'd0);
        check($sformatf("%s.halted", tag),  32'(halted_o), 32'd0);
        check($sformatf("%s.trap", tag),    32'(trap_o),   32'd0);
        check($sformatf("%s.trap_pc", tag), trap_pc_o,     32'd0);
        check($sformatf("%s.retired", tag), retired_o,     32'd0);
    endtask

    task automatic boot_through();
        reset = 1'b1;
        idle();
        for (int i = 0; i < BC; i++) begin
            step("boot");
            check("boot_hold", 32'(run_o), 32'd0);
        end
        step("boot_exit");
        check("boot_run", 32'(run_o), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        idle();
        m_st = 0; m_cnt = BC; m_pc = RV; m_ret = 0; m_tpc = 0;

        // Reset and boot hold
        step("rst0");
        step("rst1");
        check_reset_values("rst");
        boot_through();

        // Sequential fetch 0 -> 4 -> 8 -> 12
        for (int i = 0; i < 3; i++) step("seq");
        check("seq_pc", pc_out, 32'd12);
        check("seq_ret", retired_o, 32'd3);

        // Transfers from PC 8, imm 16
        jump_to(32'd8);
        drive(1, 1, 0, 0, 32'd16, 32'd0, 0, 0); step("br_taken");
        check("br_taken_pc", pc_out, 32'd24);
        jump_to(32'd8);
        drive(1, 0, 0, 0, 32'd16, 32'd0, 0, 0); step("br_not");
        check("br_not_pc", pc_out, 32'd12);
        jump_to(32'd8);
        drive(1, 1, 1, 1, 32'd16, 32'h101, 0, 0); step("jalr_wins");
        check("jalr_wins_pc", pc_out, 32'h110);
        drive(0, 0, 0, 1, 32'd0, 32'h41, 0, 0); step("jalr_lsb");
        check("jalr_lsb_pc", pc_out, 32'h40);
        drive(0, 0, 1, 0, 32'hFFFF_FFF0, 32'd0, 0, 0); step("jal_back");
        check("jal_back_pc", pc_out, 32'h30);

        // Stall with JAL pending, halt request ignored while stalled
        jump_to(32'h20);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, 32'h10, 32'd0, 1, (i == 1));
            step("stall");
            check("stall_pc", pc_out, 32'h20);
        end
        drive(0, 0, 1, 0, 32'h10, 32'd0, 0, 0); step("stall_rel");
        check("stall_rel_pc", pc_out, 32'h30);

        // Misaligned JAL traps and freezes
        jump_to(32'h40);
        drive(0, 0, 1, 0, 32'd2, 32'd0, 0, 0); step("trap");
        check("trap_flag", 32'(trap_o), 32'd1);
        check("trap_pc", trap_pc_o, 32'h40);
        check("trap_run", 32'(run_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 1, 32'h8, 32'h100, 0, 1);
            step("trap_hold");
        end
        check("trap_frozen_pc", pc_out, 32'h40);
        reset = 1'b0; idle(); step("trap_rst");
        check_reset_values("trap_rst");

        // Halt at PC 0x10 with four retired
        boot_through();
        for (int i = 0; i < 4; i++) step("pre_halt");
        drive(0, 0, 0, 0, 32'd0, 32'd0, 0, 1); step("halt");
        check("halt_flag", 32'(halted_o), 32'd1);
        check("halt_ret", retired_o, 32'd5);
        check("halt_pc", pc_out, 32'h10);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 1, 32'h8, 32'h200, 0, 0);
            step("halt_hold");
        end
        check("halt_frozen_pc", pc_out, 32'h10);

        // Reset mid-boot restarts the boot count
        reset = 1'b0; idle(); step("mb_rst");
        reset = 1'b1; step("mb_b1"); step("mb_b2");
        reset = 1'b0; step("mb_rst2");
        check_reset_values("mid_boot");
        boot_through();

        // Misaligned JALR (bit 1 survives the lsb clear)
        drive(0, 0, 0, 1, 32'd0, 32'h43, 0, 0); step("jalr_trap");
        check("jalr_trap_flag", 32'(trap_o), 32'd1);
        check("jalr_trap_pc", trap_pc_o, 32'h0);

        // Reset while stalled
        reset = 1'b0; idle(); step("ms_rst");
        boot_through();
        step("ms_seq"); step("ms_seq");
        drive(0, 0, 1, 0, 32'h40, 32'd0, 1, 0); step("ms_stall");
        reset = 1'b0; step("ms_rst2");
        check_reset_values("mid_stall");
        reset = 1'b1; idle();
        step("ms_b1"); step("ms_b2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller for the single-cycle RISC-V datapath. It owns the architectural program counter and picks the next fetch address each cycle: sequential, branch, JAL or JALR. It also runs a post-reset boot hold, stops the core on halt requests, and traps on misaligned control-transfer targets. Decode and ALU drive it; its outputs feed instruction memory and qualify register-file and data-memory write enables.

## Interface
Parameters:
- WIDTH, 32, address/data width
- RESET_VEC, 32'h0000_0000, PC value loaded by reset
- BOOT_CYCLES, 4, idle cycles after reset release before the first instruction executes (0 allowed)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-low reset
- branch_i  input  1  current instruction is a conditional branch
- branch_taken_i  input  1  ALU compare result for the branch
- jal_i  input  1  current instruction is JAL
- jalr_i  input  1  current instruction is JALR
- imm_i  input  WIDTH  sign-extended immediate
- rs1_i  input  WIDTH  rs1 read data
- stall_i  input  1  hold the PC this cycle
- halt_req_i  input  1  ECALL/EBREAK decoded
- pc_out  output  WIDTH  current PC (registered)
- pc_plus4_o  output  WIDTH  pc_out + 4, for the JAL/JALR link value
- run_o  output  1  core executing; datapath write enables = run_o & ~stall_i
- halted_o  output  1  halt state reached
- trap_o  output  1  misaligned-target trap taken
- trap_pc_o  output  WIDTH  PC of the faulting instruction
- retired_o  output  32  retired-instruction counter

## Operation
- FSM states:
  - BOOT: pc_out = RESET_VEC, run_o = 0. A down-counter loads BOOT_CYCLES at reset. Go to RUN when the counter is 0, and decrement otherwise.
  - RUN: executes instructions.
  - HALT and TRAP: terminal states. Only reset exits them.
- Target computation (all arithmetic modulo 2^WIDTH):
  - branch/JAL target = pc_out + imm_i
  - JALR target = (rs1_i + imm_i) & ~1
- Next-PC priority in RUN: jalr_i > jal_i > (branch_i & branch_taken_i) > pc_out + 4. This also resolves illegal simultaneous assertions.
- RUN cycle with stall_i = 1:
  - PC, state and retired_o all hold.
  - halt_req_i and all transfer inputs are ignored.
- RUN cycle with stall_i = 0, checked in this order:
  - halt_req_i = 1: go to HALT, PC holds, retired_o += 1 (the ECALL/EBREAK counts as retired).
  - Selected transfer target has bit[1] = 1 (misaligned): go to TRAP, trap_pc_o <= pc_out, PC holds, retired_o does not increment. A sequential PC never traps.
  - Otherwise: pc_out <= selected next PC, retired_o += 1.
- retired_o wraps from 32'hFFFF_FFFF to 0.
- In HALT and TRAP, all inputs are ignored and every output holds.

## Timing
- Reset (reset = 0 at a rising edge) gives these values at the next edge:
  - pc_out = RESET_VEC, state = BOOT
  - run_o = 0, halted_o = 0, trap_o = 0
  - trap_pc_o = 0, retired_o = 0
- Reset has priority over everything and is honoured in any state, including mid-boot and while stalled.
- run_o, halted_o and trap_o decode directly from the registered state, with no combinational input path.
- pc_plus4_o is combinational from pc_out.
- Next-PC selection is combinational from the inputs. pc_out changes only at a rising edge, so one instruction completes per non-stalled RUN cycle.
- With BOOT_CYCLES = N, run_o rises N+1 edges after the first edge that samples reset = 1.
- Transition into HALT or TRAP: halted_o or trap_o is visible in the cycle after the edge that takes it.

## Test plan
- Boot with BOOT_CYCLES = 4, RESET_VEC = 0, no transfers:
  - run_o = 0 for 4 cycles after reset release, then pc_out steps 0, 4, 8, 12.
  - retired_o = 3 after the third step.
- Transfers from PC = 8 with imm_i = 16:
  - taken branch -> PC 24
  - branch with branch_taken_i = 0 -> PC 12
  - jal_i and jalr_i both set, rs1_i = 0x101 -> PC 0x110 (JALR wins, bit 0 cleared)
- Stall: assert stall_i for 3 cycles at PC = 0x20 with jal_i set -> PC stays 0x20 and retired_o is unchanged. On release, the JAL is taken.
- Misaligned target: jal_i with imm_i = 2 at PC = 0x40 -> trap_o = 1, trap_pc_o = 0x40, run_o = 0, PC frozen. Reset returns pc_out to RESET_VEC with trap_o = 0.
- Halt: halt_req_i at PC = 0x10 with retired_o = 4 -> halted_o = 1, retired_o = 5, PC stays 0x10. Later transfer inputs have no effect.
- Reset mid-boot (2 cycles in) and reset mid-stall: every output returns to its reset value, and the boot count restarts at BOOT_CYCLES.
